// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed 8-note melody as a square wave with play/stop, octave shift and enable gating
module melody_sequencer #(
    parameter int CLK_HZ     = 25000000,
    parameter int BEAT_TICKS = 6250000,
    parameter int GAP_TICKS  = 250000,
    parameter int LOOP       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       play_pulse,
    input  logic       octave_pulse,
    output logic       speaker,
    output logic       playing,
    output logic [2:0] note_index,
    output logic [1:0] octave,
    output logic       done
);
    localparam int DW = $clog2(CLK_HZ / 440 + 1);
    localparam int CW = $clog2(2 * BEAT_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [DW-1:0] DIV_A3 = DW'(CLK_HZ / 440 - 1);
    localparam logic [DW-1:0] DIV_A4 = DW'(CLK_HZ / 880 - 1);
    localparam logic [DW-1:0] DIV_E5 = DW'(CLK_HZ / 1318 - 1);
    localparam logic [DW-1:0] DIV_A5 = DW'(CLK_HZ / 1760 - 1);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    // A divider of zero marks a rest: the speaker never toggles
    function automatic logic [DW-1:0] rom_div(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_div = DIV_A3;
            3'd1:    rom_div = DIV_A4;
            3'd3:    rom_div = DIV_E5;
            3'd4:    rom_div = DIV_A4;
            3'd6:    rom_div = DIV_A5;
            3'd7:    rom_div = DIV_A3;
            default: rom_div = '0;
        endcase
    endfunction

    function automatic logic [1:0] rom_beats(input logic [2:0] idx);
        rom_beats = (idx == 3'd3 || idx == 3'd6 || idx == 3'd7) ? 2'd2 : 2'd1;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    note_q, note_d, ld_idx;
    logic [1:0]    oct_q, oct_d, ld_beats;
    logic [DW-1:0] half_q, half_d, cur_div, cur_eff, ld_eff;
    logic [CW-1:0] dur_q, dur_d, ld_dur;
    logic [GW-1:0] gap_q, gap_d;
    logic          spk_q, spk_d, play_q, play_d, done_q, done_d;

    // Values a note load would use; the post-pulse octave so a start with an octave pulse uses the new pitch
    always_comb begin
        oct_d    = oct_q + {1'b0, octave_pulse};
        ld_idx   = (state_q == GAP && note_q != 3'd7) ? note_q + 3'd1 : 3'd0;
        ld_beats = rom_beats(ld_idx);
        ld_eff   = rom_div(ld_idx) >> oct_d;
        ld_dur   = CW'(BEAT_TICKS) * CW'(ld_beats) - CW'(1);
        cur_div  = rom_div(note_q);
        cur_eff  = cur_div >> oct_d;
    end

    // Next-state logic: abort (stop or enable low) beats every other transition, including the last gap expiry
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        half_d  = half_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        spk_d   = spk_q;
        play_d  = play_q;
        done_d  = 1'b0;
        if (state_q != IDLE && (play_pulse || !enable)) begin
            state_d = IDLE;
            note_d  = '0;
            half_d  = '0;
            dur_d   = '0;
            gap_d   = '0;
            spk_d   = 1'b0;
            play_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (play_pulse && enable) begin
                state_d = NOTE;
                note_d  = ld_idx;
                half_d  = ld_eff;
                dur_d   = ld_dur;
                spk_d   = 1'b0;
                play_d  = 1'b1;
            end
        end else if (state_q == NOTE) begin
            dur_d = dur_q - CW'(1);
            if (cur_div != '0) begin
                half_d = (half_q == '0) ? cur_eff : half_q - DW'(1);
                spk_d  = (half_q == '0) ? !spk_q : spk_q;
            end
            if (dur_q == '0) begin
                state_d = GAP;
                spk_d   = 1'b0;
                dur_d   = '0;
                gap_d   = GW'(GAP_TICKS - 1);
            end
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end else if (note_q != 3'd7 || LOOP != 0) begin
            state_d = NOTE;
            note_d  = ld_idx;
            half_d  = ld_eff;
            dur_d   = ld_dur;
        end else begin
            state_d = IDLE;
            note_d  = '0;
            play_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            note_q  <= '0;
            oct_q   <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            spk_q   <= 1'b0;
            play_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            spk_q   <= spk_d;
            play_q  <= play_d;
            done_q  <= done_d;
        end
    end

    assign speaker    = spk_q;
    assign playing    = play_q;
    assign note_index = note_q;
    assign octave     = oct_q;
    assign done       = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scenario tasks with a queue of expected event times/values for melody_sequencer
module tb_melody_sequencer;
    // Scaled clock keeps a full melody short: divs A3=567 A4=283 E5=188 A5=141
    localparam int CLK_HZ = 250000;
    localparam int BEAT   = 3000;
    localparam int GAP    = 20;
    localparam int RUN    = 11 * BEAT + 8 * GAP;

    logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, play_pulse = 1'b0, octave_pulse = 1'b0, l_play = 1'b0;
    logic       speaker, playing, done, l_speaker, l_playing, l_done;
    logic [2:0] note_index, l_note, l_prev = 3'd0;
    logic [1:0] octave, l_octave;
    int         cyc = 0, pass = 0, total = 0, t0 = 0;
    int         done_cnt = 0, done_at = -1, l_done_cnt = 0, l_wrap_at = -1;
    int         exp_q[$];

    melody_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .LOOP(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .play_pulse(play_pulse), .octave_pulse(octave_pulse),
        .speaker(speaker), .playing(playing), .note_index(note_index), .octave(octave), .done(done));

    melody_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .LOOP(1)) dut_loop (
        .clk(clk), .reset(reset), .enable(1'b1), .play_pulse(l_play), .octave_pulse(1'b0),
        .speaker(l_speaker), .playing(l_playing), .note_index(l_note), .octave(l_octave), .done(l_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record done pulses and the looping instance's 7->0 wrap, timestamped by edge number
    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc;
        end
        if (l_done) l_done_cnt <= l_done_cnt + 1;
        if (l_prev == 3'd7 && l_note == 3'd0 && l_playing && l_wrap_at < 0) l_wrap_at <= cyc;
        l_prev <= l_note;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_edge(output int at);
        logic p;
        p  = speaker;
        at = -1;
        for (int i = 0; i < 5000 && at < 0; i++) begin
            @(negedge clk);
            if (speaker !== p) at = cyc;
        end
    endtask

    task automatic start_play();
        play_pulse = 1'b1;
        @(negedge clk);
        play_pulse = 1'b0;
        t0 = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (speaker !== 1'b0) $display("FAIL reset_speaker got %b want 0", speaker); else pass++;
        total++; if (playing !== 1'b0) $display("FAIL reset_playing got %b want 0", playing); else pass++;
        total++; if (note_index !== 3'd0) $display("FAIL reset_note got %0d want 0", note_index); else pass++;
        total++; if (octave !== 2'd0) $display("FAIL reset_octave got %0d want 0", octave); else pass++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start();
        int at, e;
        enable = 1'b1;
        l_play = 1'b1;
        start_play();
        l_play = 1'b0;
        total++; if (playing !== 1'b1) $display("FAIL start_playing got %b want 1", playing); else pass++;
        total++; if (note_index !== 3'd0) $display("FAIL start_note got %0d want 0", note_index); else pass++;
        total++; if (speaker !== 1'b0) $display("FAIL start_speaker got %b want 0", speaker); else pass++;
        total++; if (l_playing !== 1'b1) $display("FAIL start_loop_playing got %b want 1", l_playing); else pass++;
        exp_q.push_back(t0 + 568);
        exp_q.push_back(t0 + 1136);
        exp_q.push_back(t0 + 1704);
        repeat (3) begin
            wait_edge(at);
            e = exp_q.pop_front();
            total++; if (at !== e) $display("FAIL a3_toggle got cycle %0d want %0d", at - t0, e - t0); else pass++;
        end
    endtask

    task automatic test_octave_mid_note();
        int at, e;
        wait_until(t0 + 3319);
        octave_pulse = 1'b1;
        @(negedge clk);
        octave_pulse = 1'b0;
        total++; if (octave !== 2'd1) $display("FAIL oct_value got %0d want 1", octave); else pass++;
        total++; if (note_index !== 3'd1) $display("FAIL oct_note got %0d want 1", note_index); else pass++;
        exp_q.push_back(t0 + 3588);
        exp_q.push_back(t0 + 3730);
        exp_q.push_back(t0 + 3872);
        exp_q.push_back(t0 + 4014);
        repeat (4) begin
            wait_edge(at);
            e = exp_q.pop_front();
            total++; if (at !== e) $display("FAIL a4_oct_toggle got cycle %0d want %0d", at - t0, e - t0); else pass++;
        end
    endtask

    task automatic test_rest();
        int bad;
        bad = 0;
        wait_until(t0 + 2 * (BEAT + GAP) + 1);
        total++; if (note_index !== 3'd2) $display("FAIL rest_note got %0d want 2", note_index); else pass++;
        repeat (BEAT - 2) begin
            if (speaker !== 1'b0 || note_index !== 3'd2 || playing !== 1'b1) bad++;
            @(negedge clk);
        end
        total++; if (bad !== 0) $display("FAIL rest_silence got %0d bad cycles want 0", bad); else pass++;
    endtask

    task automatic test_loop();
        for (int i = 0; i < 40000 && l_wrap_at < 0; i++) @(negedge clk);
        total++; if (l_wrap_at !== t0 + RUN) $display("FAIL loop_wrap got cycle %0d want %0d", l_wrap_at - t0, RUN); else pass++;
        total++; if (l_playing !== 1'b1) $display("FAIL loop_playing got %b want 1", l_playing); else pass++;
        wait_until(t0 + RUN + BEAT + GAP + 5);
        total++; if (l_note !== 3'd1) $display("FAIL loop_next_note got %0d want 1", l_note); else pass++;
        l_play = 1'b1;
        @(negedge clk);
        l_play = 1'b0;
        total++; if (l_playing !== 1'b0) $display("FAIL loop_stop got %b want 0", l_playing); else pass++;
        total++; if (l_done_cnt !== 0) $display("FAIL loop_done got %0d pulses want 0", l_done_cnt); else pass++;
    endtask

    task automatic test_full_run();
        for (int i = 0; i < 40000 && done_cnt == 0; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        total++; if (done_at !== t0 + RUN) $display("FAIL done_time got cycle %0d want %0d", done_at - t0, RUN); else pass++;
        total++; if (done_cnt !== 1) $display("FAIL done_count got %0d want 1", done_cnt); else pass++;
        total++; if (playing !== 1'b0) $display("FAIL end_playing got %b want 0", playing); else pass++;
        total++; if (note_index !== 3'd0) $display("FAIL end_note got %0d want 0", note_index); else pass++;
        total++; if (speaker !== 1'b0) $display("FAIL end_speaker got %b want 0", speaker); else pass++;
    endtask

    task automatic test_stop();
        start_play();
        wait_until(t0 + 3500);
        total++; if (speaker !== 1'b1 || note_index !== 3'd1) $display("FAIL stop_pre got spk %b note %0d want 1 1", speaker, note_index); else pass++;
        play_pulse = 1'b1;
        @(negedge clk);
        play_pulse = 1'b0;
        total++; if ({playing, speaker, note_index, done} !== 6'b0) $display("FAIL stop_outputs got %b want 000000", {playing, speaker, note_index, done}); else pass++;
        repeat (5) @(negedge clk);
        total++; if (playing !== 1'b0) $display("FAIL stop_stays_idle got %b want 0", playing); else pass++;
        start_play();
        wait_until(t0 + 3500);
        total++; if (speaker !== 1'b1 || note_index !== 3'd1) $display("FAIL dis_pre got spk %b note %0d want 1 1", speaker, note_index); else pass++;
        enable = 1'b0;
        @(negedge clk);
        total++; if ({playing, speaker, note_index, done} !== 6'b0) $display("FAIL dis_outputs got %b want 000000", {playing, speaker, note_index, done}); else pass++;
        start_play();
        repeat (3) @(negedge clk);
        total++; if (playing !== 1'b0) $display("FAIL dis_play_ignored got %b want 0", playing); else pass++;
        total++; if (done_cnt !== 1) $display("FAIL stop_no_done got %0d pulses want 1", done_cnt); else pass++;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_gap();
        start_play();
        wait_until(t0 + 2 * BEAT + GAP + 5);
        total++; if (playing !== 1'b1 || note_index !== 3'd1 || octave !== 2'd1) $display("FAIL gap_pre got play %b note %0d oct %0d want 1 1 1", playing, note_index, octave); else pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if ({speaker, playing, note_index, octave, done} !== 8'b0) $display("FAIL gap_reset got %b want 00000000", {speaker, playing, note_index, octave, done}); else pass++;
    endtask

    task automatic test_octave_wrap();
        int e;
        for (int i = 1; i <= 4; i++) begin
            octave_pulse = 1'b1;
            @(negedge clk);
            octave_pulse = 1'b0;
            exp_q.push_back(i % 4);
            e = exp_q.pop_front();
            total++; if (int'(octave) !== e) $display("FAIL oct_wrap got %0d want %0d", octave, e); else pass++;
        end
        total++; if (playing !== 1'b0) $display("FAIL oct_idle got %b want 0", playing); else pass++;
    endtask

    task automatic test_play_with_octave();
        int at;
        octave_pulse = 1'b1;
        start_play();
        octave_pulse = 1'b0;
        total++; if (octave !== 2'd1 || playing !== 1'b1) $display("FAIL both_pulse got oct %0d play %b want 1 1", octave, playing); else pass++;
        exp_q.push_back(t0 + 284);
        wait_edge(at);
        total++; if (at !== exp_q[0]) $display("FAIL both_first_rise got cycle %0d want 284", at - t0); else pass++;
        void'(exp_q.pop_front());
        play_pulse = 1'b1;
        @(negedge clk);
        play_pulse = 1'b0;
        total++; if (playing !== 1'b0) $display("FAIL both_stop got %b want 0", playing); else pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_start();
        test_octave_mid_note();
        test_rest();
        test_loop();
        test_full_run();
        test_stop();
        test_reset_mid_gap();
        test_octave_wrap();
        test_play_with_octave();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
